// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM (IF/ID/EX/MEM/WB/TRAP) driving datapath strobes and counters.
// Latency: 4 cycles for ALU/branch, 5 for LW/SW, plus one cycle per data-memory wait state.
// Backpressure: IF holds until instr_valid; MEM holds until dmem_ready, optionally trapping after MEM_TIMEOUT waits.
module multicycle_ctrl #(
  parameter int ENABLE_BRANCH_EXT = 0,
  parameter int MEM_TIMEOUT       = 0,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             Zero,
  input  logic             LessThan,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             loadPC,
  output logic [3:0]       ALUCtrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             illegal_instr,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam bit          BR_EXT  = (ENABLE_BRANCH_EXT != 0);
  localparam bit          TO_EN   = (MEM_TIMEOUT > 0);
  // Wait-count value at which the next unanswered MEM cycle trips the timeout.
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  state_t      state_q, state_d;
  logic [31:0] ir;
  logic [31:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero, f7_alt;
  logic       is_lw, is_sw, is_br, is_imm, is_reg;
  logic       legal;
  logic       br_taken;
  logic       timeout_hit;
  logic       unused_ir_fields;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
  assign is_br  = (opcode == OP_BRANCH);
  assign is_imm = (opcode == OP_IMM);
  assign is_reg = (opcode == OP_REG);

  // Register and immediate fields belong to the datapath, not the controller.
  assign unused_ir_fields = ^{ir[24:15], ir[11:7]};

  assign timeout_hit = TO_EN && !dmem_ready && (wait_cnt == TO_LAST);
  assign state_o     = state_q;

  // Legality check of the latched instruction word.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_BRANCH: begin
        case (funct3)
          3'b000:                 legal = 1'b1;
          3'b001, 3'b100, 3'b101: legal = BR_EXT;
          default:                legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        case (funct3)
          3'b001:  legal = f7_zero;
          3'b101:  legal = f7_zero || f7_alt;
          default: legal = 1'b1;
        endcase
      end
      OP_REG:  legal = f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      default: legal = 1'b0;
    endcase
  end

  // ALU operation and operand select, decoded purely from IR so they are never X.
  always_comb begin
    ALUCtrl = ALU_ADD;
    ALUSrc  = is_lw || is_sw || is_imm;
    if (is_br) begin
      ALUCtrl = ALU_SUB;
    end else if (is_imm || is_reg) begin
      case (funct3)
        3'b000:  ALUCtrl = (is_reg && f7_alt) ? ALU_SUB : ALU_ADD;
        3'b001:  ALUCtrl = ALU_SLL;
        3'b010:  ALUCtrl = ALU_SLT;
        3'b100:  ALUCtrl = ALU_XOR;
        3'b101:  ALUCtrl = f7_alt ? ALU_SRA : ALU_SRL;
        3'b110:  ALUCtrl = ALU_OR;
        3'b111:  ALUCtrl = ALU_AND;
        default: ALUCtrl = ALU_ADD;
      endcase
    end
  end

  // Branch condition from the datapath flags.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = !Zero;
      3'b100:  br_taken = LessThan;
      3'b101:  br_taken = !LessThan;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and per-state strobes; imem_req is also gated by reset so every strobe is low in reset.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = rst;
        if (instr_valid) state_d = S_ID;
      end
      S_ID: state_d = legal ? S_EX : S_TRAP;
      S_EX: state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (dmem_ready)       state_d = S_WB;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB: begin
        loadPC   = 1'b1;
        RegWrite = is_reg || is_imm || is_lw;
        MemToReg = is_lw;
        PCSrc    = is_br && br_taken;
        state_d  = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  // State register and instruction latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      ir      <= 32'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IF) && instr_valid) ir <= instr;
    end
  end

  // MEM wait counter: counts unanswered MEM cycles, cleared outside MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 32'd0;
    end else if ((state_q == S_MEM) && !dmem_ready) begin
      wait_cnt <= wait_cnt + 32'd1;
    end else begin
      wait_cnt <= 32'd0;
    end
  end

  // Sticky trap causes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      if ((state_q == S_ID) && !legal)      illegal_instr <= 1'b1;
      if ((state_q == S_MEM) && timeout_hit) mem_timeout  <= 1'b1;
    end
  end

  // Performance counters, frozen once trapped; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (state_q == S_WB)   instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instructions against two controller configurations, scoreboard-checked.
// Instance 0: extended branches on, MEM timeout 4. Instance 1: BEQ only, no timeout.
// A negedge monitor pops one expectation per retirement (loadPC) or trap entry.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0;
  logic        Zero = 1'b0;
  logic        LessThan = 1'b0;
  logic        dmem_ready = 1'b0;
  bit          sel = 1'b0;

  logic        imem_req [2];
  logic        pcsrc [2];
  logic        alusrc [2];
  logic        regwrite [2];
  logic        memtoreg [2];
  logic        loadpc [2];
  logic [3:0]  aluctrl [2];
  logic        memread [2];
  logic        memwrite [2];
  logic        illegal [2];
  logic        tmo [2];
  logic [31:0] cyc [2];
  logic [31:0] ret [2];
  logic [2:0]  st [2];

  always #5 clk = ~clk;

  multicycle_ctrl #(.ENABLE_BRANCH_EXT(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .Zero(Zero),
    .LessThan(LessThan), .dmem_ready(dmem_ready), .imem_req(imem_req[0]), .PCSrc(pcsrc[0]),
    .ALUSrc(alusrc[0]), .RegWrite(regwrite[0]), .MemToReg(memtoreg[0]), .loadPC(loadpc[0]),
    .ALUCtrl(aluctrl[0]), .MemRead(memread[0]), .MemWrite(memwrite[0]),
    .illegal_instr(illegal[0]), .mem_timeout(tmo[0]), .cycle_cnt(cyc[0]),
    .instret_cnt(ret[0]), .state_o(st[0])
  );

  multicycle_ctrl #(.ENABLE_BRANCH_EXT(0), .MEM_TIMEOUT(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .Zero(Zero),
    .LessThan(LessThan), .dmem_ready(dmem_ready), .imem_req(imem_req[1]), .PCSrc(pcsrc[1]),
    .ALUSrc(alusrc[1]), .RegWrite(regwrite[1]), .MemToReg(memtoreg[1]), .loadPC(loadpc[1]),
    .ALUCtrl(aluctrl[1]), .MemRead(memread[1]), .MemWrite(memwrite[1]),
    .illegal_instr(illegal[1]), .mem_timeout(tmo[1]), .cycle_cnt(cyc[1]),
    .instret_cnt(ret[1]), .state_o(st[1])
  );

  typedef struct {
    bit         trap;
    logic [3:0] alu;
    logic       src, rw, m2r, pcs, ill, tmo;
    int         cyc, ret, mr, mw;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4032D293;
  localparam logic [31:0] I_SRLI = 32'h0032D293;
  localparam logic [31:0] I_BADR = 32'h4020C1B3;
  localparam logic [31:0] I_BADS = 32'h40209093;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t rt(input logic [3:0] alu, input logic src, input logic rw,
                              input logic m2r, input logic pcs, input int c, input int mr, input int mw);
    exp_t e;
    e.trap = 1'b0; e.alu = alu; e.src = src; e.rw = rw; e.m2r = m2r; e.pcs = pcs;
    e.ill = 1'b0; e.tmo = 1'b0; e.cyc = c; e.ret = 1; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  function automatic exp_t tr(input logic ill, input logic to, input int c, input int mr, input int mw);
    exp_t e;
    e.trap = 1'b1; e.alu = 4'd0; e.src = 1'b0; e.rw = 1'b0; e.m2r = 1'b0; e.pcs = 1'b0;
    e.ill = ill; e.tmo = to; e.cyc = c; e.ret = 0; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  // Monitor: counts memory-strobe cycles and checks each retirement / trap entry against the queue.
  int mr_n = 0, mw_n = 0, age = 0;
  bit in_trap = 1'b0, post = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      mr_n = 0; mw_n = 0; age = 0; in_trap = 1'b0; post = 1'b0;
    end else begin
      if (memread[sel])  mr_n++;
      if (memwrite[sel]) mw_n++;
      if (post) begin
        chk("cycle_cnt_after_wb", cyc[sel], cur.cyc);
        chk("instret_cnt_after_wb", ret[sel], cur.ret);
        post = 1'b0;
      end
      if (loadpc[sel]) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_retire: got loadPC=1, expected no retirement (t=%0t)", $time);
        end else begin
          cur = q.pop_front();
          chk("event_is_trap", 32'd0, 32'(cur.trap));
          chk("ALUCtrl", aluctrl[sel], cur.alu);
          chk("ALUSrc", alusrc[sel], cur.src);
          chk("RegWrite", regwrite[sel], cur.rw);
          chk("MemToReg", memtoreg[sel], cur.m2r);
          chk("PCSrc", pcsrc[sel], cur.pcs);
          chk("memread_cycles", mr_n, cur.mr);
          chk("memwrite_cycles", mw_n, cur.mw);
          mr_n = 0; mw_n = 0; post = 1'b1;
        end
      end
      if (st[sel] == 3'd5) begin
        if (!in_trap) begin
          in_trap = 1'b1; age = 0;
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_trap: got state=TRAP, expected no trap (t=%0t)", $time);
          end else begin
            cur = q.pop_front();
            chk("event_is_trap", 32'd1, 32'(cur.trap));
            chk("illegal_instr", illegal[sel], cur.ill);
            chk("mem_timeout", tmo[sel], cur.tmo);
            chk("cycle_cnt_at_trap", cyc[sel], cur.cyc);
            chk("instret_cnt_at_trap", ret[sel], cur.ret);
            chk("memread_cycles", mr_n, cur.mr);
            chk("memwrite_cycles", mw_n, cur.mw);
          end
        end else begin
          age++;
          if (age == 4) begin
            chk("cycle_cnt_frozen", cyc[sel], cur.cyc);
            chk("memwrite_cycles_in_trap", mw_n, cur.mw);
            chk("memread_cycles_in_trap", mr_n, cur.mr);
          end
        end
      end
    end
  end

  // Pulse reset and check the reset state of the watched instance.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_state", st[sel], 3'd0);
    chk("rst_cycle_cnt", cyc[sel], 32'd0);
    chk("rst_instret_cnt", ret[sel], 32'd0);
    chk("rst_imem_req", imem_req[sel], 1'b0);
    chk("rst_illegal", illegal[sel], 1'b0);
    chk("rst_timeout", tmo[sel], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Issue one instruction; dmem_ready is pulsed for one cycle after posedge (rdy_at+1) past the fetch.
  task automatic run(input bit s, input logic [31:0] iw, input logic z, input logic lt,
                     input int rdy_at, input exp_t e);
    sel = s;
    do_reset();
    q.push_back(e);
    instr = iw; instr_valid = 1'b1; Zero = z; LessThan = lt; dmem_ready = 1'b0;
    #1;
    chk("imem_req_in_if", imem_req[sel], 1'b1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 1; i < 14; i++) begin
      @(posedge clk); #1;
      dmem_ready = (i == rdy_at);
    end
    chk("events_pending", q.size(), 32'd0);
    q.delete();
  endtask

  // Reset asserted while an LW sits in MEM: everything must clear at once, nothing retires.
  task automatic reset_mid_mem();
    sel = 1'b0;
    do_reset();
    instr = I_LW; instr_valid = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mem_state", st[0], 3'd3);
    chk("mid_mem_memread", memread[0], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_memread", memread[0], 1'b0);
    chk("async_rst_state", st[0], 3'd0);
    chk("async_rst_cycle_cnt", cyc[0], 32'd0);
    chk("async_rst_instret_cnt", ret[0], 32'd0);
    chk("async_rst_regwrite", regwrite[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    chk("post_rst_instret_cnt", ret[0], 32'd0);
    chk("events_pending", q.size(), 32'd0);
  endtask

  initial begin
    #2;
    run(0, I_ADD,  0, 0, -1, rt(4'b0010, 0, 1, 0, 0, 4, 0, 0));
    run(0, I_SUB,  0, 0, -1, rt(4'b0110, 0, 1, 0, 0, 4, 0, 0));
    run(0, I_SRAI, 0, 0, -1, rt(4'b1010, 1, 1, 0, 0, 4, 0, 0));
    run(0, I_SRLI, 0, 0, -1, rt(4'b1000, 1, 1, 0, 0, 4, 0, 0));
    run(0, I_BADR, 0, 0, -1, tr(1, 0, 2, 0, 0));
    run(0, I_BADS, 0, 0, -1, tr(1, 0, 2, 0, 0));
    run(0, I_LW,   0, 0,  5, rt(4'b0010, 1, 1, 1, 0, 8, 4, 0));
    run(0, I_BNE,  0, 0, -1, rt(4'b0110, 0, 0, 0, 1, 4, 0, 0));
    run(0, I_BNE,  1, 0, -1, rt(4'b0110, 0, 0, 0, 0, 4, 0, 0));
    run(0, I_BLT,  0, 1, -1, rt(4'b0110, 0, 0, 0, 1, 4, 0, 0));
    run(0, I_BGE,  0, 1, -1, rt(4'b0110, 0, 0, 0, 0, 4, 0, 0));
    run(1, I_BNE,  0, 0, -1, tr(1, 0, 2, 0, 0));
    run(1, I_BEQ,  1, 0, -1, rt(4'b0110, 0, 0, 0, 1, 4, 0, 0));
    run(0, I_SW,   0, 0, -1, tr(0, 1, 7, 0, 4));
    run(0, I_SW,   0, 0,  5, rt(4'b0010, 1, 0, 0, 0, 8, 0, 4));
    run(1, I_LW,   0, 0,  9, rt(4'b0010, 1, 1, 1, 0, 12, 8, 0));
    reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
